// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the ALU issue/dispatch stage.
package tensor_core_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int OPCODE_W   = 3;
  localparam int NUM_REGS   = 8;

  // Opcodes are passed straight through to the ALU; the names document the
  // encoding the downstream ALU uses.
  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    WB   = 2'b10
  } dispatch_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = 16'hFFFF;
    end else begin
      result = value + 16'h0001;
    end
    return result;
  endfunction

endpackage

// File: rtl/alu_dispatch_regfile.sv
// 8x8 register file for the dispatch stage: two operand read ports, one
// debug read port, a host write port and a writeback write port. When both
// write ports hit the same register on one edge, the writeback value wins.
module alu_dispatch_regfile
  import tensor_core_pkg::*;
(
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [REG_ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0]     rd1_data,
  input  logic [REG_ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0]     rd2_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  input  logic                  host_we,
  input  logic [REG_ADDR_W-1:0] host_waddr,
  input  logic [DATA_W-1:0]     host_wdata,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage update: writeback takes priority over a host write to the same entry.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_we && (wb_addr == 3'(i))) begin
          regs[i] <= wb_data;
        end else if (host_we && (host_waddr == 3'(i))) begin
          regs[i] <= host_wdata;
        end
      end
    end
  end

  // Reads are combinational and show pre-edge contents (no bypass).
  assign rd1_data = regs[rd1_addr];
  assign rd2_data = regs[rd2_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage in front of the 8-bit ALU. Accepts one instruction over a
// valid/ready handshake, presents opcode and register operands to the ALU,
// waits ALU_LATENCY cycles, then writes the ALU result back.
// Optional build macro ALU_DISPATCH_RETIRE_COUNT_EN adds a saturating
// 16-bit retired-instruction counter on port retired_count_out.
module alu_dispatch
  import tensor_core_pkg::*;
#(
  parameter int ALU_LATENCY = 1
)
(
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  instr_valid_in,
  output logic                  instr_ready_out,
  input  logic [OPCODE_W-1:0]   instr_opcode_in,
  input  logic [REG_ADDR_W-1:0] instr_dest_in,
  input  logic [REG_ADDR_W-1:0] instr_src1_in,
  input  logic [REG_ADDR_W-1:0] instr_src2_in,
  output logic [OPCODE_W-1:0]   alu_opcode_out,
  output logic [DATA_W-1:0]     alu_input1_out,
  output logic [DATA_W-1:0]     alu_input2_out,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic                  host_we_in,
  input  logic [REG_ADDR_W-1:0] host_waddr_in,
  input  logic [DATA_W-1:0]     host_wdata_in,
  input  logic [REG_ADDR_W-1:0] dbg_raddr_in,
  output logic [DATA_W-1:0]     dbg_rdata_out,
  output logic                  busy_out,
  output logic                  done_out
`ifdef ALU_DISPATCH_RETIRE_COUNT_EN
  ,
  output logic [15:0]           retired_count_out
`endif
);

  localparam logic [2:0] LAT_VAL = 3'(ALU_LATENCY);

  dispatch_state_t       state;
  dispatch_state_t       state_next;
  logic                  accept;
  logic                  wb_en;
  logic [2:0]            wait_cnt;
  logic [REG_ADDR_W-1:0] dest;
  logic [DATA_W-1:0]     rd1_data;
  logic [DATA_W-1:0]     rd2_data;

  alu_dispatch_regfile u_regfile (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .rd1_addr   (instr_src1_in),
    .rd1_data   (rd1_data),
    .rd2_addr   (instr_src2_in),
    .rd2_data   (rd2_data),
    .dbg_addr   (dbg_raddr_in),
    .dbg_data   (dbg_rdata_out),
    .host_we    (host_we_in),
    .host_waddr (host_waddr_in),
    .host_wdata (host_wdata_in),
    .wb_we      (wb_en),
    .wb_addr    (dest),
    .wb_data    (alu_result_in)
  );

  // State register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus accept/writeback strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    wb_en      = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid_in) begin
          accept     = 1'b1;
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        // The edge that takes the counter from 1 to 0 is the last WAIT edge.
        if (wait_cnt <= 3'd1) begin
          state_next = WB;
        end else begin
          state_next = WAIT;
        end
      end
      WB: begin
        wb_en      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ALU-facing registers: loaded on accept, held otherwise; latency countdown in WAIT.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      alu_opcode_out <= 3'b000;
      alu_input1_out <= 8'h00;
      alu_input2_out <= 8'h00;
      dest           <= 3'b000;
      wait_cnt       <= 3'd0;
    end else begin
      if (accept) begin
        alu_opcode_out <= instr_opcode_in;
        alu_input1_out <= rd1_data;
        alu_input2_out <= rd2_data;
        dest           <= instr_dest_in;
        wait_cnt       <= LAT_VAL;
      end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  // Status decoded directly from the state flops.
  assign instr_ready_out = (state == IDLE);
  assign busy_out        = (state != IDLE);
  assign done_out        = (state == WB);

`ifdef ALU_DISPATCH_RETIRE_COUNT_EN
  logic [15:0] retired_count;

  // Count completed writebacks, holding at all-ones.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      retired_count <= 16'h0000;
    end else if (wb_en) begin
      retired_count <= sat_inc16(retired_count);
    end
  end

  assign retired_count_out = retired_count;
`endif

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Issue stage directly upstream of the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads both operands from an internal 8x8 register file.
- Drives the ALU opcode and operand inputs, waits the ALU latency, then writes the ALU result back to the destination register.
- A host write port loads the register file; a debug port reads it.

Parameters:
- ALU_LATENCY, 1, cycles from the ALU inputs being stable to alu_result_in being valid (legal range 1..7).
- NUM_REGS, 8, register file depth; fixed by the 3-bit register fields.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- instr_valid_in  input  1  instruction present.
- instr_ready_out  output  1  block can accept an instruction.
- instr_opcode_in  input  3  ALU opcode.
- instr_dest_in  input  3  destination register index.
- instr_src1_in  input  3  operand-1 register index.
- instr_src2_in  input  3  operand-2 register index.
- alu_opcode_out  output  3  to ALU opcode_in.
- alu_input1_out  output  8  to ALU alu_input1.
- alu_input2_out  output  8  to ALU alu_input2.
- alu_result_in  input  8  from ALU alu_output.
- host_we_in  input  1  host register write enable.
- host_waddr_in  input  3  host write address.
- host_wdata_in  input  8  host write data.
- dbg_raddr_in  input  3  debug read address.
- dbg_rdata_out  output  8  debug read data, combinational.
- busy_out  output  1  high when the FSM is not in IDLE.
- done_out  output  1  one-cycle pulse in the writeback cycle.

Behaviour:
- Reset, asynchronous, while reset_in=1:
  - FSM goes to IDLE.
  - All registers, alu_opcode_out, alu_input1_out and alu_input2_out are 0.
  - busy_out=0, done_out=0, wait counter 0.
  - instr_ready_out=1 once reset deasserts.
- States: IDLE, WAIT, WB.
- IDLE:
  - instr_ready_out=1.
  - On a clock edge with instr_valid_in=1:
    - Latch the opcode into alu_opcode_out.
    - Latch regs[src1] into alu_input1_out and regs[src2] into alu_input2_out.
    - Latch the destination index, load the counter with ALU_LATENCY, go to WAIT.
- WAIT:
  - instr_ready_out=0; ALU outputs are held stable.
  - Counter decrements each edge; when it reaches 0, go to WB.
  - WAIT therefore lasts exactly ALU_LATENCY cycles.
- WB:
  - done_out=1 for this cycle only.
  - At the closing edge, regs[dest] is written with alu_result_in and the FSM returns to IDLE.
  - ALU outputs keep their last values.
- Timing:
  - Accept edge at cycle 0; done_out high in cycle ALU_LATENCY+1.
  - Next accept possible at the edge ending cycle ALU_LATENCY+2.
  - Throughput is one instruction per ALU_LATENCY+2 cycles.
- Operand reads at the accept edge see register contents before any write on that same edge (read-before-write). No internal bypass.
- src1 == src2 is legal; both operands get the same value. dest may equal either source.
- Host writes are accepted in any state.
- Host write and writeback on the same edge to the same address: the writeback wins. Different addresses: both take effect.
- instr_valid_in outside IDLE is ignored; the instruction fields are not sampled, and the producer must hold them until ready.
- All 8 opcode values pass through unmodified; no decoding takes place here.
- Reset mid-operation aborts with no writeback; the register file clears.
- Data width is 8 bits throughout; the result is taken as-is, with no extension or saturation.

Optional Feature:
- Macro: ALU_DISPATCH_RETIRE_COUNT_EN.
- When defined:
  - Adds output port retired_count_out [15:0].
  - The counter increments at each WB closing edge and saturates at 16'hFFFF.
  - Reset value is 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package tensor_core_pkg holds:
  - DATA_W=8, REG_ADDR_W=3, OPCODE_W=3.
  - alu_opcode_t enum, with 3'b000 = OP_ADD.
  - dispatch_state_t enum {IDLE, WAIT, WB}.
- Sub-module alu_dispatch_regfile:
  - 8x8 storage with async reset.
  - Two combinational read ports plus the debug read port.
  - Two write ports, with the writeback port given priority.

Test Plan:
1. Reset then host writes r1=5, r2=3; issue ADD r3=r1+r2 → alu_input1_out=5, alu_input2_out=3 the cycle after accept; done_out high in cycle 2 (ALU_LATENCY=1); dbg read r3=8.
2. Back-to-back valid held high with two instructions → second accepted only after WB; instr_ready_out low for exactly ALU_LATENCY+1 cycles between accepts.
3. Host write r4=9 on the same edge as a writeback to r4 of value 8 → r4 reads 8. Repeat with host write to r5 → r4=8, r5=9.
4. ADD r1=r1+r1 with r1=7 → both operands 7, r1 becomes 14 after WB.
5. Assert reset_in during WAIT → busy_out=0 immediately, no done_out pulse, all registers read 0.
6. With ALU_DISPATCH_RETIRE_COUNT_EN defined, retire 3 instructions → retired_count_out=3. Preload the counter to 16'hFFFF via force and retire one more → stays 16'hFFFF.
